// File: rtl/ex_stage_muldiv.sv
// rtl/ex_stage_muldiv.sv - EX stage with forwarding, ALU and iterative mul/div
module ex_stage_muldiv #(
    parameter int XLEN    = 32,
    parameter int RA_W    = 5,
    parameter int MUL_LAT = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            mem_stall,
    input  logic            id_valid,
    input  logic [3:0]      id_op,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic [XLEN-1:0] id_a,
    input  logic [XLEN-1:0] id_b,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_alu_src,
    input  logic [RA_W-1:0] id_rd,
    input  logic            id_reg_write,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            wb_reg_write,
    output logic            ex_ready,
    output logic            ex_mem_valid,
    output logic [XLEN-1:0] ex_mem_result,
    output logic [RA_W-1:0] ex_mem_rd,
    output logic            ex_mem_reg_write
);
    localparam int SH_W    = $clog2(XLEN);
    localparam int CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    state_t state, state_n;

    logic [3:0]        op_q;
    logic [RA_W-1:0]   rd_q;
    logic              rw_q;
    logic [XLEN-1:0]   a_q, b_q, quo_q, rem_q, dvs_q;
    logic [CNT_W-1:0]  cnt;

    logic              accept, is_mul, is_div, signed_div;
    logic [XLEN-1:0]   fwd_a, fwd_b, op_a, op_b, alu_res, done_res;
    logic [SH_W-1:0]   shamt;
    logic [2*XLEN-1:0] prod;
    logic [XLEN:0]     rem_sh;
    logic [XLEN-1:0]   rem_diff;
    logic              rem_ge, a_neg_q, b_neg_q;

    assign ex_ready   = (state == S_IDLE) & ~mem_stall;
    assign accept     = id_valid & ex_ready & ~flush;
    assign is_mul     = (id_op == 4'd10) | (id_op == 4'd11);
    assign is_div     = (id_op[3:2] == 2'b11);
    assign signed_div = ~id_op[0];

    // EX/MEM beats MEM/WB; register 0 always reads its file value
    assign fwd_a = (id_rs != '0 && ex_mem_valid && ex_mem_reg_write && ex_mem_rd == id_rs) ? ex_mem_result :
                   (id_rs != '0 && wb_reg_write && wb_rd == id_rs) ? wb_data : id_a;
    assign fwd_b = (id_rt != '0 && ex_mem_valid && ex_mem_reg_write && ex_mem_rd == id_rt) ? ex_mem_result :
                   (id_rt != '0 && wb_reg_write && wb_rd == id_rt) ? wb_data : id_b;
    assign op_a  = fwd_a;
    assign op_b  = id_alu_src ? id_imm : fwd_b;
    assign shamt = op_b[SH_W-1:0];

    // single-cycle ALU
    always_comb begin
        alu_res = '0;
        case (id_op)
            4'd0:    alu_res = op_a + op_b;
            4'd1:    alu_res = op_a - op_b;
            4'd2:    alu_res = op_a & op_b;
            4'd3:    alu_res = op_a | op_b;
            4'd4:    alu_res = op_a ^ op_b;
            4'd5:    alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'd6:    alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            4'd7:    alu_res = op_a << shamt;
            4'd8:    alu_res = op_a >> shamt;
            4'd9:    alu_res = $unsigned($signed(op_a) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    // one restoring-divide step on the magnitudes
    assign rem_sh   = {rem_q, quo_q[XLEN-1]};
    assign rem_ge   = (rem_sh >= {1'b0, dvs_q});
    assign rem_diff = rem_sh[XLEN-1:0] - dvs_q;

    assign prod    = {{XLEN{1'b0}}, a_q} * {{XLEN{1'b0}}, b_q};
    assign a_neg_q = ~op_q[0] & a_q[XLEN-1];
    assign b_neg_q = ~op_q[0] & b_q[XLEN-1];

    // final mul/div result with sign fixup; divide-by-zero is overridden, signed overflow falls out naturally
    always_comb begin
        done_res = '0;
        case (op_q)
            4'd10:       done_res = prod[XLEN-1:0];
            4'd11:       done_res = prod[2*XLEN-1:XLEN];
            4'd12, 4'd13: done_res = (b_q == '0) ? '1 : ((a_neg_q ^ b_neg_q) ? -quo_q : quo_q);
            default:     done_res = (b_q == '0) ? a_q : (a_neg_q ? -rem_q : rem_q);
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // FSM next state; the MUL state covers MUL_LAT-1 cycles, DIV covers XLEN iterations
    always_comb begin
        state_n = state;
        if (flush) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && is_mul)      state_n = (MUL_LAT == 1) ? S_DONE : S_MUL;
                    else if (accept && is_div) state_n = S_DIV;
                end
                S_MUL, S_DIV: if (cnt == '0) state_n = S_DONE;
                S_DONE:       if (!mem_stall) state_n = S_IDLE;
                default:      state_n = S_IDLE;
            endcase
        end
    end

    // operand capture and iterative datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            rd_q  <= '0;
            rw_q  <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt   <= '0;
        end else if (accept && (is_mul || is_div)) begin
            op_q  <= id_op;
            rd_q  <= id_rd;
            rw_q  <= id_reg_write;
            a_q   <= op_a;
            b_q   <= op_b;
            quo_q <= (signed_div && op_a[XLEN-1]) ? -op_a : op_a;
            dvs_q <= (signed_div && op_b[XLEN-1]) ? -op_b : op_b;
            rem_q <= '0;
            cnt   <= is_div ? CNT_W'(XLEN - 1) : CNT_W'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
        end else begin
            if (state == S_DIV) begin
                rem_q <= rem_ge ? rem_diff : rem_sh[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], rem_ge};
            end
            if ((state == S_MUL || state == S_DIV) && cnt != '0) cnt <= cnt - 1'b1;
        end
    end

    // EX/MEM pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_mem_valid     <= 1'b0;
            ex_mem_result    <= '0;
            ex_mem_rd        <= '0;
            ex_mem_reg_write <= 1'b0;
        end else if (flush) begin
            ex_mem_valid     <= 1'b0;
            ex_mem_reg_write <= 1'b0;
        end else if (!mem_stall) begin
            if (accept && !(is_mul || is_div)) begin
                ex_mem_valid     <= 1'b1;
                ex_mem_result    <= alu_res;
                ex_mem_rd        <= id_rd;
                ex_mem_reg_write <= id_reg_write;
            end else if (state == S_DONE) begin
                ex_mem_valid     <= 1'b1;
                ex_mem_result    <= done_res;
                ex_mem_rd        <= rd_q;
                ex_mem_reg_write <= rw_q;
            end else begin
                ex_mem_valid     <= 1'b0;
                ex_mem_reg_write <= 1'b0;
            end
        end
    end
endmodule
